div32_iterative: RTL and testbench
==================================

Name: div32_iterative

Overview:
- Multi-cycle 32-bit integer divider, signed and unsigned, for MIPS DIV/DIVU.
- Performs the inverse of the combinational ALU's MUL path.
- Sits beside the ALU in EX and produces the values for the HI/LO registers: Quotient goes to LO, Remainder goes to HI.
- Uses restoring division, one quotient bit per cycle. The pipeline stalls on Busy.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is verified.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request a divide; sampled only in IDLE.
- Signed  input  1  1 = DIV (two's complement), 0 = DIVU; captured with Start.
- A  input  32  dividend; captured with Start.
- B  input  32  divisor; captured with Start.
- Busy  output  1  high while a divide is in progress.
- Done  output  1  one-cycle pulse when results are valid.
- Quotient  output  32  result for LO; held until the next completion.
- Remainder  output  32  result for HI; held until the next completion.
- DivByZero  output  1  set with Done when B == 0; held like the results.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - Busy = 0, Done = 0, Quotient = 0, Remainder = 0, DivByZero = 0.
  - Iteration counter = 0.
  - An in-flight operation is discarded and produces no Done.
- States: IDLE, RUN, FIX.
  - Busy = (state != IDLE), decoded combinationally from the state register.
- IDLE, at edge k with Start = 1:
  - Latch Signed and the sign bits of A and B.
  - Load magnitudes: |A| and |B| when Signed, raw values otherwise. |0x80000000| = 0x80000000 as unsigned.
  - Clear the partial remainder; counter = 31; go to RUN.
- RUN, edges k+1 .. k+32:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor in 33-bit arithmetic.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - At counter == 0, go to FIX; otherwise decrement the counter.
- FIX, edge k+33:
  - Apply signs when Signed: quotient is negated if the dividend sign differs from the divisor sign; remainder takes the dividend sign (truncating division).
  - Register Quotient, Remainder and DivByZero; Done = 1; go to IDLE.
- Done:
  - High for exactly one cycle, after edge k+33. Cleared at edge k+34 unless a new completion occurs.
  - Latency from the Start edge to Done is 33 cycles, fixed and independent of operand values.
- Start while Busy is ignored. Operands and outputs are unaffected.
- Start in the Done cycle (state is IDLE) is accepted: back-to-back issue, new Done 33 cycles later.
- Divide by zero (B == 0, either mode):
  - Quotient = 0xFFFFFFFF, Remainder = original A, DivByZero = 1.
  - Same latency as any other divide.
  - The signed sign fixup is bypassed for this case.
- Signed overflow (0x80000000 / 0xFFFFFFFF): Quotient = 0x80000000, Remainder = 0, DivByZero = 0.
- Outputs change only at the FIX edge or on Reset. Quotient and Remainder stay stable between completions.

Decomposition:
- Shared package div_pkg contains:
  - state encoding constants IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2;
  - DIV_LATENCY = 33;
  - DIV_WIDTH = 32.
- One combinational sub-module, div_step:
  - inputs: 32-bit partial remainder, dividend MSB, 32-bit divisor;
  - outputs: next partial remainder and quotient bit.
  - Instantiated once inside the RUN datapath.

Test Plan:
- Unsigned 100/7: Start with Signed = 0, A = 100, B = 7 → Busy high for 33 cycles; Done pulses once 33 cycles after Start; Quotient = 14, Remainder = 2, DivByZero = 0.
- Signed cases:
  - A = 0xFFFFFFF9 (−7), B = 2 → Quotient = 0xFFFFFFFD, Remainder = 0xFFFFFFFF.
  - A = 7, B = 0xFFFFFFFE → Quotient = 0xFFFFFFFD, Remainder = 1.
- Divide by zero: A = 0x12345678, B = 0, both modes → Quotient = 0xFFFFFFFF, Remainder = 0x12345678, DivByZero = 1, latency 33.
- Corner operands, A = 0x80000000, B = 0xFFFFFFFF:
  - Signed → Quotient = 0x80000000, Remainder = 0.
  - Unsigned → Quotient = 0, Remainder = 0x80000000.
- Handshake:
  - Start 100/7; pulse Start with A = 9, B = 3 at cycle 5 → ignored; result 14 r 2.
  - Start 9/3 in the Done cycle → accepted; Quotient = 3, Remainder = 0 exactly 33 cycles later.
- Reset mid-operation: assert Reset 10 cycles into a divide → Busy, Done and outputs go to 0 immediately without a clock edge; no Done after Reset release; the next Start works normally.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative divider.
package div_pkg;
  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = 33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] rem,
  input  logic                 msb,
  input  logic [DIV_WIDTH-1:0] dvs,
  output logic [DIV_WIDTH-1:0] rem_next,
  output logic                 qbit
);
  logic [DIV_WIDTH:0] cand;
  logic [DIV_WIDTH:0] diff;

  // cand < 2*dvs, so a non-negative diff always fits in DIV_WIDTH bits
  always_comb begin
    cand     = {rem, msb};
    diff     = cand - {1'b0, dvs};
    qbit     = ~diff[DIV_WIDTH];
    rem_next = qbit ? diff[DIV_WIDTH-1:0] : cand[DIV_WIDTH-1:0];
  end
endmodule

// File: rtl/div32_iterative.sv
// Multi-cycle signed/unsigned divider for DIV/DIVU: LO = Quotient, HI = Remainder.
module div32_iterative
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
)(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);
  localparam int CW = $clog2(WIDTH);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] a_orig;
  logic [WIDTH-1:0] rem_next;
  logic [CW-1:0]    cnt;
  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic             dz;
  logic             qbit;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (cnt == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign Busy = (state != IDLE);

  div_step u_step (
    .rem      (rem),
    .msb      (dvd[WIDTH-1]),
    .dvs      (dvs),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rem       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      a_orig    <= '0;
      cnt       <= '0;
      sgn       <= 1'b0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      dz        <= 1'b0;
      Done      <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            sgn    <= Signed;
            a_neg  <= A[WIDTH-1];
            b_neg  <= B[WIDTH-1];
            dvd    <= (Signed && A[WIDTH-1]) ? -A : A;
            dvs    <= (Signed && B[WIDTH-1]) ? -B : B;
            a_orig <= A;
            dz     <= (B == '0);
            rem    <= '0;
            cnt    <= CW'(WIDTH - 1);
          end
        end
        RUN: begin
          rem <= rem_next;
          dvd <= {dvd[WIDTH-2:0], qbit};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          Done      <= 1'b1;
          DivByZero <= dz;
          // divide-by-zero skips sign fixup and reports the raw dividend
          if (dz) begin
            Quotient  <= '1;
            Remainder <= a_orig;
          end else begin
            Quotient  <= (sgn && (a_neg ^ b_neg)) ? -dvd : dvd;
            Remainder <= (sgn && a_neg) ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div32_iterative.sv
// Scoreboard bench for div32_iterative: directed vectors, decoupled monitor.
module tb_div32_iterative;
  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        Signed;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        DivByZero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  div32_iterative dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Signed    (Signed),
    .A         (A),
    .B         (B),
    .Busy      (Busy),
    .Done      (Done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivByZero (DivByZero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", n, act, exp, cyc);
    end
  endtask

  always @(negedge Clk) begin : monitor
    exp_t e;
    if (!Reset && Done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got Done=1 want none (cyc %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("quotient", Quotient, e.q);
        chk("remainder", Remainder, e.r);
        chk("divbyzero", {31'b0, DivByZero}, {31'b0, e.dz});
        chk("latency", cyc, e.at);
      end
    end
  end

  // Call at a negedge; Start is sampled at the following posedge.
  task automatic issue(input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eq,
                       input logic [31:0] er, input logic edz,
                       input bit push);
    Start  = 1'b1;
    Signed = s;
    A      = a;
    B      = b;
    if (push) sb.push_back('{q: eq, r: er, dz: edz, at: cyc + 34});
    @(negedge Clk);
    Start = 1'b0;
    A     = 32'hDEAD_BEEF;
    B     = 32'h0000_0001;
    chk("busy_after_start", {31'b0, Busy}, 32'd1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no Done want Done within 40 cycles");
    end
  endtask

  task automatic run(input logic s, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eq,
                     input logic [31:0] er, input logic edz);
    @(negedge Clk);
    issue(s, a, b, eq, er, edz, 1'b1);
    wait_done();
    @(negedge Clk);
    chk("done_one_cycle", {31'b0, Done}, 32'd0);
    chk("busy_idle", {31'b0, Busy}, 32'd0);
    chk("quotient_held", Quotient, eq);
    chk("remainder_held", Remainder, er);
  endtask

  initial begin
    Reset  = 1'b1;
    Start  = 1'b0;
    Signed = 1'b0;
    A      = '0;
    B      = '0;
    #1;
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_done", {31'b0, Done}, 32'd0);
    chk("rst_q", Quotient, 32'd0);
    chk("rst_r", Remainder, 32'd0);
    chk("rst_dz", {31'b0, DivByZero}, 32'd0);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    run(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0);
    run(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    run(1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);

    // Start while busy is ignored, Start in the Done cycle is accepted
    @(negedge Clk);
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    repeat (4) @(negedge Clk);
    Start = 1'b1;
    A     = 32'd9;
    B     = 32'd3;
    @(negedge Clk);
    Start = 1'b0;
    chk("busy_ignored_start", {31'b0, Busy}, 32'd1);
    wait_done();
    issue(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1);
    wait_done();

    // Reset mid-operation discards the divide and clears outputs at once
    @(negedge Clk);
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    repeat (9) @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, Busy}, 32'd0);
    chk("mid_rst_done", {31'b0, Done}, 32'd0);
    chk("mid_rst_q", Quotient, 32'd0);
    chk("mid_rst_r", Remainder, 32'd0);
    chk("mid_rst_dz", {31'b0, DivByZero}, 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (40) @(negedge Clk);
    chk("post_rst_idle", {31'b0, Busy}, 32'd0);
    run(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    repeat (3) @(negedge Clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
